// File: rtl/alu_exec_ctrl_if.sv
// Request/response bundle for the ALU execution controller: decode request,
// multiply operands, and the registered control/result outputs.
interface alu_exec_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       ALUop;
  logic [5:0]       function_code;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_ctr;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, flush, ALUop, function_code, a, b,
    input  alu_ctr, busy, done, illegal, product_hi, product_lo
  );

  modport slave (
    input  start, flush, ALUop, function_code, a, b,
    output alu_ctr, busy, done, illegal, product_hi, product_lo
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// ALU control decoder with a shift-add multi-cycle unsigned multiplier
// (optional early termination once the remaining multiplier bits are zero).
module alu_exec_ctrl #(
  parameter int         WIDTH      = 32,
  parameter bit         EARLY_TERM = 1'b0,
  parameter logic [5:0] MULT_FUNCT = 6'b011000
) (
  input logic            clk,
  input logic            reset,
  alu_exec_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2:0]         alu_ctr_r;
  logic               busy_r;
  logic               done_r;
  logic               illegal_r;
  logic [WIDTH-1:0]   prod_hi_r;
  logic [WIDTH-1:0]   prod_lo_r;

  logic [4:0]         decode_s;
  logic [WIDTH:0]     add_sum_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] acc_final_s;
  logic [WIDTH-1:0]   mplier_shift_s;
  logic [CNT_W-1:0]   shamt_s;
  logic               last_iter_s;

  // Result packing is {is_mul, illegal, alu_ctr}.
  function automatic logic [4:0] decode(input logic [2:0] op, input logic [5:0] fc);
    logic [4:0] res;
    if (op != 3'b111) begin
      res = {2'b00, op};
    end else if (fc == MULT_FUNCT) begin
      res = 5'b10000;
    end else begin
      case (fc)
        6'b000010: res = 5'b00101;
        6'b000011: res = 5'b00110;
        6'b000100: res = 5'b00000;
        6'b000101: res = 5'b00001;
        6'b000111: res = 5'b00100;
        default:   res = 5'b01000;
      endcase
    end
    return res;
  endfunction

  // Decode of the request currently presented on the bus.
  always_comb begin
    decode_s = decode(bus.ALUop, bus.function_code);
  end

  // One shift-add iteration plus the exit test and early-exit realignment.
  always_comb begin
    add_sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + ({1'b0, mcand_r} & {(WIDTH+1){mplier_r[0]}});
    acc_step_s     = {add_sum_s, acc_r[WIDTH-1:1]};
    mplier_shift_s = mplier_r >> 1;
    shamt_s        = CNT_W'(WIDTH - 1) - cnt_r;
    if (cnt_r == CNT_W'(WIDTH - 1)) begin
      last_iter_s = 1'b1;
    end else if (EARLY_TERM && (mplier_shift_s == {WIDTH{1'b0}})) begin
      last_iter_s = 1'b1;
    end else begin
      last_iter_s = 1'b0;
    end
    // Skipped iterations would only shift, so shift the remainder in one go.
    if (EARLY_TERM) begin
      acc_final_s = acc_step_s >> shamt_s;
    end else begin
      acc_final_s = acc_step_s;
    end
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      alu_ctr_r <= 3'b000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      prod_hi_r <= {WIDTH{1'b0}};
      prod_lo_r <= {WIDTH{1'b0}};
    end else begin
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      if (bus.flush) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.start) begin
              alu_ctr_r <= decode_s[2:0];
              if (decode_s[4]) begin
                state_r  <= MUL;
                busy_r   <= 1'b1;
                cnt_r    <= {CNT_W{1'b0}};
                acc_r    <= {(2*WIDTH){1'b0}};
                mcand_r  <= bus.a;
                mplier_r <= bus.b;
              end else begin
                done_r    <= 1'b1;
                illegal_r <= decode_s[3];
              end
            end
          end
          MUL: begin
            acc_r    <= acc_step_s;
            mplier_r <= mplier_shift_s;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (last_iter_s) begin
              state_r   <= IDLE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              prod_hi_r <= acc_final_s[2*WIDTH-1:WIDTH];
              prod_lo_r <= acc_final_s[WIDTH-1:0];
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.alu_ctr    = alu_ctr_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.illegal    = illegal_r;
  assign bus.product_hi = prod_hi_r;
  assign bus.product_lo = prod_lo_r;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench: one DUT with full-length multiply, one with early
// termination, both WIDTH=8, checked against a behavioural model.
module tb_alu_exec_ctrl;
  localparam int W = 8;
  localparam logic [5:0] MULF = 6'b011000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl_if #(.WIDTH(W)) bus0 ();
  alu_exec_ctrl_if #(.WIDTH(W)) bus1 ();

  alu_exec_ctrl #(.WIDTH(W), .EARLY_TERM(1'b0), .MULT_FUNCT(MULF)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  alu_exec_ctrl #(.WIDTH(W), .EARLY_TERM(1'b1), .MULT_FUNCT(MULF)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = full-length DUT, 1 = early-term DUT, 2 = both.
  task automatic drive(input int sel, input logic st, input logic fl, input logic [2:0] op,
                       input logic [5:0] fc, input logic [7:0] av, input logic [7:0] bv);
    if (sel != 1) begin
      bus0.start = st; bus0.flush = fl; bus0.ALUop = op;
      bus0.function_code = fc; bus0.a = av; bus0.b = bv;
    end
    if (sel != 0) begin
      bus1.start = st; bus1.flush = fl; bus1.ALUop = op;
      bus1.function_code = fc; bus1.a = av; bus1.b = bv;
    end
  endtask

  // {busy, done, illegal, alu_ctr[2:0], product_hi, product_lo}
  function automatic logic [21:0] snap(input int sel);
    if (sel == 0)
      return {bus0.busy, bus0.done, bus0.illegal, bus0.alu_ctr, bus0.product_hi, bus0.product_lo};
    else
      return {bus1.busy, bus1.done, bus1.illegal, bus1.alu_ctr, bus1.product_hi, bus1.product_lo};
  endfunction

  // {illegal, alu_ctr} for a non-multiply request.
  function automatic logic [3:0] exp_decode(input logic [2:0] op, input logic [5:0] fc);
    if (op != 3'b111) return {1'b0, op};
    case (fc)
      6'b000010: return 4'b0101;
      6'b000011: return 4'b0110;
      6'b000100: return 4'b0000;
      6'b000101: return 4'b0001;
      6'b000111: return 4'b0100;
      default:   return 4'b1000;
    endcase
  endfunction

  // Busy cycles: always W without early exit, else up to the highest set bit of b.
  function automatic int exp_iters(input int early, input logic [7:0] bv);
    int n;
    if (early == 0) return W;
    n = 1;
    for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(2, 1'b1, 1'b1, 3'b111, MULF, 8'hFF, 8'hFF);
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (snap(s) !== 22'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %h expected %h", s, snap(s), 22'h0);
      end
    end
    reset = 1'b0;
    drive(2, 1'b0, 1'b0, 3'b000, 6'b000000, 8'h00, 8'h00);
    step();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (snap(s) !== 22'h0) begin
        n_fail++;
        $display("FAIL post_reset_idle dut%0d: got %h expected %h", s, snap(s), 22'h0);
      end
    end
  endtask

  task automatic test_decode_fixed();
    logic [2:0] ops [4] = '{3'b111, 3'b111, 3'b010, 3'b111};
    logic [5:0] fcs [4] = '{6'b000010, 6'b000111, 6'b000011, 6'b001111};
    logic [3:0] exps[4] = '{4'b0101, 4'b0100, 4'b0010, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      drive(2, 1'b1, 1'b0, ops[i], fcs[i], 8'h00, 8'h00);
      step();
      for (int s = 0; s < 2; s++) begin
        n_checks++;
        if (snap(s)[21:16] !== {2'b01, exps[i]}) begin
          n_fail++;
          $display("FAIL decode_fixed_%0d dut%0d: got %b expected %b", i, s, snap(s)[21:16], {2'b01, exps[i]});
        end
      end
    end
    drive(2, 1'b0, 1'b0, 3'b101, 6'b000010, 8'h00, 8'h00);
    step();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (snap(s)[21:16] !== 6'b000000) begin
        n_fail++;
        $display("FAIL decode_hold dut%0d: got %b expected %b", s, snap(s)[21:16], 6'b000000);
      end
    end
  endtask

  task automatic test_decode_random();
    logic [2:0] op, held;
    logic [5:0] fc;
    logic       st;
    logic [5:0] exp;
    held = 3'b000;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      op = 3'($urandom);
      fc = (i % 3 == 0) ? 6'($urandom_range(2, 7)) : 6'($urandom);
      if (op == 3'b111 && fc == MULF) fc = 6'b000101;
      drive(2, st, 1'b0, op, fc, 8'($urandom), 8'($urandom));
      step();
      if (st) begin
        exp  = {2'b01, exp_decode(op, fc)};
        held = exp[2:0];
      end else begin
        exp = {3'b000, held};
      end
      for (int s = 0; s < 2; s++) begin
        n_checks++;
        if (snap(s)[21:16] !== exp) begin
          n_fail++;
          $display("FAIL decode_rand_%0d dut%0d: got %b expected %b", i, s, snap(s)[21:16], exp);
        end
      end
    end
    drive(2, 1'b0, 1'b0, 3'b000, 6'b000000, 8'h00, 8'h00);
    step();
  endtask

  task automatic run_mul(input int sel, input logic [7:0] av, input logic [7:0] bv, input bit noise);
    int          cyc;
    int          exp_cyc;
    logic [15:0] prod;
    exp_cyc = exp_iters(sel, bv);
    prod    = 16'(av) * 16'(bv);
    drive(sel, 1'b1, 1'b0, 3'b111, MULF, av, bv);
    step();
    drive(sel, 1'b0, 1'b0, 3'b000, 6'b000000, 8'h00, 8'h00);
    cyc = 0;
    while (snap(sel)[21] && cyc < 40) begin
      if (noise)
        drive(sel, 1'($urandom_range(0, 1)), 1'b0, 3'($urandom), 6'($urandom), 8'($urandom), 8'($urandom));
      step();
      cyc++;
    end
    drive(sel, 1'b0, 1'b0, 3'b000, 6'b000000, 8'h00, 8'h00);
    n_checks++;
    if (cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL mul_busy_len dut%0d a=%h b=%h: got %0d expected %0d", sel, av, bv, cyc, exp_cyc);
    end
    n_checks++;
    if (snap(sel) !== {3'b010, 3'b000, prod}) begin
      n_fail++;
      $display("FAIL mul_done dut%0d a=%h b=%h: got %h expected %h", sel, av, bv, snap(sel), {3'b010, 3'b000, prod});
    end
    step();
    n_checks++;
    if (snap(sel) !== {3'b000, 3'b000, prod}) begin
      n_fail++;
      $display("FAIL mul_hold dut%0d a=%h b=%h: got %h expected %h", sel, av, bv, snap(sel), {3'b000, 3'b000, prod});
    end
  endtask

  task automatic test_mult();
    logic [7:0] av, bv;
    run_mul(0, 8'hFF, 8'hFF, 1'b1);
    run_mul(1, 8'h03, 8'h01, 1'b0);
    run_mul(1, 8'h03, 8'h00, 1'b0);
    run_mul(1, 8'hFF, 8'hFF, 1'b1);
    run_mul(1, 8'hA5, 8'h80, 1'b0);
    for (int i = 0; i < 12; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom) >> $urandom_range(0, 7);
      run_mul(0, av, bv, 1'(i % 2));
      run_mul(1, av, bv, 1'(i % 2));
    end
  endtask

  task automatic test_flush();
    run_mul(0, 8'h05, 8'h07, 1'b0);
    drive(0, 1'b1, 1'b0, 3'b111, MULF, 8'hFF, 8'hFF);
    step();
    drive(0, 1'b0, 1'b0, 3'b000, 6'b000000, 8'h00, 8'h00);
    step();
    step();
    drive(0, 1'b1, 1'b1, 3'b111, 6'b000010, 8'h11, 8'h22);
    step();
    drive(0, 1'b0, 1'b0, 3'b000, 6'b000000, 8'h00, 8'h00);
    n_checks++;
    if (snap(0) !== {6'b000000, 16'd35}) begin
      n_fail++;
      $display("FAIL flush_in_mul: got %h expected %h", snap(0), {6'b000000, 16'd35});
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (snap(0) !== {6'b000000, 16'd35}) begin
        n_fail++;
        $display("FAIL flush_no_done_%0d: got %h expected %h", i, snap(0), {6'b000000, 16'd35});
      end
    end
    drive(0, 1'b1, 1'b1, 3'b111, 6'b000010, 8'h00, 8'h00);
    step();
    drive(0, 1'b0, 1'b0, 3'b000, 6'b000000, 8'h00, 8'h00);
    n_checks++;
    if (snap(0) !== {6'b000000, 16'd35}) begin
      n_fail++;
      $display("FAIL flush_beats_start: got %h expected %h", snap(0), {6'b000000, 16'd35});
    end
  endtask

  task automatic test_reset_in_mul();
    drive(2, 1'b1, 1'b0, 3'b111, MULF, 8'hFF, 8'hFF);
    step();
    drive(2, 1'b0, 1'b0, 3'b000, 6'b000000, 8'h00, 8'h00);
    step();
    step();
    reset = 1'b1;
    drive(2, 1'b1, 1'b1, 3'b111, 6'b000010, 8'h00, 8'h00);
    step();
    reset = 1'b0;
    drive(2, 1'b0, 1'b0, 3'b000, 6'b000000, 8'h00, 8'h00);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (snap(s) !== 22'h0) begin
        n_fail++;
        $display("FAIL reset_in_mul dut%0d: got %h expected %h", s, snap(s), 22'h0);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step();
      for (int s = 0; s < 2; s++) begin
        n_checks++;
        if (snap(s) !== 22'h0) begin
          n_fail++;
          $display("FAIL reset_no_done_%0d dut%0d: got %h expected %h", i, s, snap(s), 22'h0);
        end
      end
    end
    run_mul(0, 8'h12, 8'h34, 1'b0);
    run_mul(1, 8'h12, 8'h34, 1'b0);
  endtask

  initial begin
    test_reset();
    test_decode_fixed();
    test_decode_random();
    test_mult();
    test_flush();
    test_reset_in_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
